// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a one-byte output buffer.
// The line is sampled mid-bit by a per-bit counter; a completed byte is held
// on rx_data/rx_valid until consumed, and overrun/frame_err report dropped
// or malformed frames with single-cycle pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned     CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_e;

    logic             meta_q;
    logic             rx_s_q;
    state_e           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       idx_q,       idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       rx_data_q,   rx_data_d;
    logic             rx_valid_q,  rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;
    logic             deliver;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make both flops sample the
            // pre-edge values, giving a true two-stage shift.
            meta_q <= rs_rx;
            rx_s_q <= meta_q;
        end
    end

    // State, counter, shift register and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Frame decoder: next state, bit counter, bit index and shift register.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path through the case statement can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        deliver     = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A start bit that is already high again was a glitch.
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        deliver = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                // A broken line must return high before a new start counts.
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output buffer: load on delivery when free or consumed the same cycle,
    // otherwise drop the new byte and flag overrun.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        if (deliver) begin
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int unsigned CPB = 16;

    logic       clk;
    logic       reset;
    logic       rs_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Observations gathered on the falling edge, away from the active edge.
    int unsigned ferr_cnt   = 0;
    int unsigned ovr_cnt    = 0;
    bit          valid_seen = 1'b0;
    logic [7:0]  got_q[$];

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .rs_rx     (rs_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and record of accepted bytes.
    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (rx_valid) valid_seen = 1'b1;
        if (rx_valid && rx_ready) got_q.push_back(rx_data);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        ferr_cnt   = 0;
        ovr_cnt    = 0;
        valid_seen = 1'b0;
        got_q.delete();
    endtask

    // One 8N1 frame, LSB first; stop_bit = 0 forces a framing error.
    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        rs_rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rs_rx = data[i];
            repeat (CPB) tick();
        end
        rs_rx = stop_bit;
        repeat (CPB) tick();
        rs_rx = 1'b1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 400 && !rx_valid; i++) tick();
        check(tag, rx_valid, 1);
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rs_rx    = 1'b1;
        rx_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state.
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 8'h00);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun, 0);

        // Single byte, consumer not ready.
        clear_obs();
        send_byte(8'h55, 1'b1);
        wait_valid("t1_valid");
        check("t1_data", rx_data, 8'h55);
        check("t1_ferr", ferr_cnt, 0);
        check("t1_ovr", ovr_cnt, 0);
        consume();
        check("t1_consumed", rx_valid, 0);
        check("t1_data_hold", rx_data, 8'h55);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        check("t1_ready_idle", rx_valid, 0);

        // Back-to-back frames, consumer answers one cycle after each valid.
        repeat (5) tick();
        clear_obs();
        fork
            begin
                send_byte(8'hA3, 1'b1);
                send_byte(8'h07, 1'b1);
            end
            begin
                for (int n = 0; n < 2; n++) begin
                    wait_valid("t2_valid");
                    tick();
                    consume();
                end
            end
        join
        repeat (4) tick();
        check("t2_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("t2_first", got_q[0], 8'hA3);
            check("t2_second", got_q[1], 8'h07);
        end
        check("t2_ovr", ovr_cnt, 0);

        // Overrun: second byte dropped while the first is unconsumed.
        clear_obs();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        repeat (4) tick();
        check("t3_valid", rx_valid, 1);
        check("t3_data", rx_data, 8'h12);
        check("t3_ovr_once", ovr_cnt, 1);
        consume();

        // Framing error, line held low, then a clean frame.
        repeat (5) tick();
        clear_obs();
        send_byte(8'hFF, 1'b0);
        rs_rx = 1'b0;
        repeat (40) tick();
        rs_rx = 1'b1;
        check("t4_ferr_once", ferr_cnt, 1);
        check("t4_no_valid", valid_seen, 0);
        repeat (20) tick();
        send_byte(8'hC5, 1'b1);
        wait_valid("t4_after_valid");
        check("t4_after_data", rx_data, 8'hC5);
        check("t4_ferr_total", ferr_cnt, 1);
        consume();

        // Short glitch, then a real frame.
        repeat (5) tick();
        clear_obs();
        rs_rx = 1'b0;
        repeat (4) tick();
        rs_rx = 1'b1;
        repeat (40) tick();
        check("t5_no_valid", valid_seen, 0);
        check("t5_no_ferr", ferr_cnt, 0);
        send_byte(8'h3C, 1'b1);
        wait_valid("t5_valid");
        check("t5_data", rx_data, 8'h3C);

        // Reset during the last data bit of 0x99 (line high there, so the
        // rest of the frame contains no falling edge); 0x3C is still buffered.
        repeat (5) tick();
        fork
            send_byte(8'h99, 1'b1);
            begin
                repeat (130) tick();
                reset = 1'b1;
                tick();
                check("t6_rst_valid", rx_valid, 0);
                check("t6_rst_data", rx_data, 8'h00);
                check("t6_rst_ferr", frame_err, 0);
                check("t6_rst_ovr", overrun, 0);
                repeat (2) tick();
                reset = 1'b0;
                clear_obs();
            end
        join
        repeat (40) tick();
        check("t6_no_valid", valid_seen, 0);
        check("t6_no_ferr", ferr_cnt, 0);
        send_byte(8'h5A, 1'b1);
        wait_valid("t6_valid");
        check("t6_data", rx_data, 8'h5A);
        check("t6_ovr", ovr_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
